pkt_arbiter: RTL and testbench
==============================

PKT_ARBITER -- requirements
Module: pkt_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 512, AXIS data width in bits; KEEP_W = DATA_W/8.
REQ-002 SHALL have parameter LEN_W, default 16, width of the byte-length output.
REQ-003 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports AXIS_RX0_TDATA/TKEEP/TVALID/TLAST  in  DATA_W/KEEP_W/1/1  requester 0 stream, plus AXIS_RX0_TREADY  out  1.
REQ-006 SHALL have ports AXIS_RX1_TDATA/TKEEP/TVALID/TLAST  in  DATA_W/KEEP_W/1/1  requester 1 stream, plus AXIS_RX1_TREADY  out  1.
REQ-007 SHALL have ports AXIS_TX_TDATA/TKEEP/TVALID/TLAST  out  DATA_W/KEEP_W/1/1  merged output stream, plus AXIS_TX_TREADY  in  1.
REQ-008 SHALL have ports AXIS_LEN_TDATA  out  LEN_W  byte count of the last forwarded packet; AXIS_LEN_TVALID  out  1; AXIS_LEN_TREADY  in  1.

Function
REQ-009 SHALL implement FSM states IDLE, GRANT0, GRANT1; packets are never interleaved on TX.
REQ-010 In IDLE, the FSM SHALL grant when (RX0_TVALID|RX1_TVALID) and the length slot is free (LEN_TVALID=0, or LEN_TVALID&LEN_TREADY this cycle).
REQ-011 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, that one wins.
REQ-012 The grant SHALL take effect the cycle after the IDLE decision (1-cycle arbitration latency); in IDLE, TX_TVALID=0 and both RX_TREADY=0.
REQ-013 In GRANTn, TX_TDATA/TKEEP/TVALID/TLAST SHALL mirror RXn combinationally, RXn_TREADY SHALL equal TX_TREADY, and the other RX_TREADY SHALL be 0.
REQ-014 In GRANTn, TX_TDATA/TKEEP/TLAST SHALL be driven from RXn; in IDLE they SHALL be 0.
REQ-015 A beat is accepted when TX_TVALID&TX_TREADY; the byte counter SHALL add popcount(TKEEP) on every accepted non-last beat.
REQ-016 On an accepted TLAST beat, the block SHALL load the length slot with counter+popcount(TKEEP), clear the counter, record the last-grant identity, and return to IDLE.
REQ-017 LEN_TVALID SHALL rise the cycle after the TLAST beat and stay high with TDATA stable until LEN_TREADY; the slot holds one entry.
REQ-018 Length arithmetic SHALL saturate at 2^LEN_W-1; no wrap-around.
REQ-019 A sparse TKEEP (non-contiguous) SHALL be counted by popcount, not by position.
REQ-020 RX TVALID deasserting mid-packet SHALL stall the grant (no timeout, no release) until TLAST is accepted.
REQ-021 A one-beat packet (TLAST on first beat) SHALL yield length = popcount of that beat.
REQ-022 A stalled length slot SHALL block the next grant but SHALL NOT stall the packet currently in flight.

Reset
REQ-023 reset SHALL asynchronously force state IDLE, counter 0, length slot empty (LEN_TVALID=0, LEN_TDATA=0), last-grant=1 so requester 0 wins first.
REQ-024 While reset is high, all TREADY and TVALID outputs SHALL be 0; a packet in flight at reset is abandoned and produces no length.

Structure
REQ-025 A shared package SHALL hold the FSM state enum and the DATA_W/KEEP_W/LEN_W defaults.
REQ-026 The keep-popcount SHALL be a sub-module keep_popcount (KEEP_W in, clog2(KEEP_W+1) out, combinational).

Verification
REQ-027 Both RX valid at once, 2-beat packets, full TKEEP, TX_TREADY=1 -> RX0 packet first, then RX1; LEN outputs 128, then 128.
REQ-028 RX0 sends 3 beats, last TKEEP=0x0000_0000_0000_000F -> LEN=132, LEN_TVALID one cycle after TLAST.
REQ-029 LEN_TREADY held 0 after first packet, RX1 pending -> RX1 not granted (RX1_TREADY=0) until LEN_TREADY pulses; the first LEN value is held stable.
REQ-030 RX0 mid-packet with TX_TREADY toggling and RX0_TVALID gaps -> no RX1 beats interleaved; length equals the sum of accepted beats only.
REQ-031 1100 full beats in one packet -> LEN saturates at 65535.
REQ-032 reset asserted mid-packet -> outputs 0 immediately; after release, RX0 granted first and no stale length emitted.

Source files
------------

// File: rtl/pkt_arbiter_pkg.sv
// rtl/pkt_arbiter_pkg.sv - shared defaults and FSM state type for pkt_arbiter
package pkt_arbiter_pkg;

   localparam int DEF_DATA_W = 512;
   localparam int DEF_KEEP_W = DEF_DATA_W / 8;
   localparam int DEF_LEN_W  = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/pkt_arbiter_if.sv
// rtl/pkt_arbiter_if.sv - two requester streams, merged stream and length stream of pkt_arbiter
interface pkt_arbiter_if
   import pkt_arbiter_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W
) ();

   localparam int KEEP_W = DATA_W / 8;

   logic [DATA_W-1:0] AXIS_RX0_TDATA;
   logic [KEEP_W-1:0] AXIS_RX0_TKEEP;
   logic              AXIS_RX0_TVALID;
   logic              AXIS_RX0_TLAST;
   logic              AXIS_RX0_TREADY;

   logic [DATA_W-1:0] AXIS_RX1_TDATA;
   logic [KEEP_W-1:0] AXIS_RX1_TKEEP;
   logic              AXIS_RX1_TVALID;
   logic              AXIS_RX1_TLAST;
   logic              AXIS_RX1_TREADY;

   logic [DATA_W-1:0] AXIS_TX_TDATA;
   logic [KEEP_W-1:0] AXIS_TX_TKEEP;
   logic              AXIS_TX_TVALID;
   logic              AXIS_TX_TLAST;
   logic              AXIS_TX_TREADY;

   logic [LEN_W-1:0]  AXIS_LEN_TDATA;
   logic              AXIS_LEN_TVALID;
   logic              AXIS_LEN_TREADY;

   modport slave (
      input  AXIS_RX0_TDATA, AXIS_RX0_TKEEP, AXIS_RX0_TVALID, AXIS_RX0_TLAST,
      output AXIS_RX0_TREADY,
      input  AXIS_RX1_TDATA, AXIS_RX1_TKEEP, AXIS_RX1_TVALID, AXIS_RX1_TLAST,
      output AXIS_RX1_TREADY,
      output AXIS_TX_TDATA, AXIS_TX_TKEEP, AXIS_TX_TVALID, AXIS_TX_TLAST,
      input  AXIS_TX_TREADY,
      output AXIS_LEN_TDATA, AXIS_LEN_TVALID,
      input  AXIS_LEN_TREADY
   );

   modport master (
      output AXIS_RX0_TDATA, AXIS_RX0_TKEEP, AXIS_RX0_TVALID, AXIS_RX0_TLAST,
      input  AXIS_RX0_TREADY,
      output AXIS_RX1_TDATA, AXIS_RX1_TKEEP, AXIS_RX1_TVALID, AXIS_RX1_TLAST,
      input  AXIS_RX1_TREADY,
      input  AXIS_TX_TDATA, AXIS_TX_TKEEP, AXIS_TX_TVALID, AXIS_TX_TLAST,
      output AXIS_TX_TREADY,
      input  AXIS_LEN_TDATA, AXIS_LEN_TVALID,
      output AXIS_LEN_TREADY
   );

endinterface

// File: rtl/keep_popcount.sv
// rtl/keep_popcount.sv - combinational count of set TKEEP bits
module keep_popcount #(
   parameter  int KEEP_W = 64,
   localparam int CNT_W  = $clog2(KEEP_W + 1)
) (
   input  logic [KEEP_W-1:0] keep,
   output logic [CNT_W-1:0]  count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < KEEP_W; i++) begin
         count = count + CNT_W'(keep[i]);
      end
   end

endmodule

// File: rtl/pkt_arbiter.sv
// rtl/pkt_arbiter.sv - round-robin packet arbiter of two streams with per-packet byte length output
module pkt_arbiter
   import pkt_arbiter_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input logic          clk,
   input logic          reset,
   pkt_arbiter_if.slave bus
);

   localparam int KEEP_W = DATA_W / 8;
   localparam int PC_W   = $clog2(KEEP_W + 1);
   localparam logic [LEN_W:0] LEN_MAX = {1'b0, {LEN_W{1'b1}}};

   arb_state_t        state;
   logic              last_grant;
   logic [LEN_W-1:0]  byte_cnt;
   logic [LEN_W-1:0]  len_data;
   logic              len_valid;

   logic [DATA_W-1:0] tx_data;
   logic [KEEP_W-1:0] tx_keep;
   logic              tx_valid;
   logic              tx_last;
   logic              rx0_ready;
   logic              rx1_ready;
   logic [PC_W-1:0]   beat_bytes;
   logic [LEN_W:0]    len_sum;
   logic [LEN_W-1:0]  len_next;
   logic              beat_acc;
   logic              slot_free;
   logic              any_req;

   // The granted requester is wired straight through; IDLE drives zeros.
   always_comb begin
      tx_data   = '0;
      tx_keep   = '0;
      tx_valid  = 1'b0;
      tx_last   = 1'b0;
      rx0_ready = 1'b0;
      rx1_ready = 1'b0;
      case (state)
         GRANT0: begin
            tx_data   = bus.AXIS_RX0_TDATA;
            tx_keep   = bus.AXIS_RX0_TKEEP;
            tx_valid  = bus.AXIS_RX0_TVALID;
            tx_last   = bus.AXIS_RX0_TLAST;
            rx0_ready = bus.AXIS_TX_TREADY;
         end
         GRANT1: begin
            tx_data   = bus.AXIS_RX1_TDATA;
            tx_keep   = bus.AXIS_RX1_TKEEP;
            tx_valid  = bus.AXIS_RX1_TVALID;
            tx_last   = bus.AXIS_RX1_TLAST;
            rx1_ready = bus.AXIS_TX_TREADY;
         end
         default: ;
      endcase
   end

   keep_popcount #(.KEEP_W(KEEP_W)) u_keep_popcount (
      .keep  (tx_keep),
      .count (beat_bytes)
   );

   // One spare bit catches the carry so the running length clamps instead of wrapping.
   assign len_sum   = {1'b0, byte_cnt} + (LEN_W + 1)'(beat_bytes);
   assign len_next  = (len_sum > LEN_MAX) ? LEN_MAX[LEN_W-1:0] : len_sum[LEN_W-1:0];
   assign beat_acc  = tx_valid && bus.AXIS_TX_TREADY;
   assign slot_free = !len_valid || bus.AXIS_LEN_TREADY;
   assign any_req   = bus.AXIS_RX0_TVALID || bus.AXIS_RX1_TVALID;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         byte_cnt   <= '0;
         len_data   <= '0;
         len_valid  <= 1'b0;
      end else begin
         if (len_valid && bus.AXIS_LEN_TREADY) begin
            len_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (any_req && slot_free) begin
                  if (bus.AXIS_RX0_TVALID && (!bus.AXIS_RX1_TVALID || last_grant)) begin
                     state <= GRANT0;
                  end else begin
                     state <= GRANT1;
                  end
               end
            end
            GRANT0, GRANT1: begin
               if (beat_acc) begin
                  if (tx_last) begin
                     len_data   <= len_next;
                     len_valid  <= 1'b1;
                     byte_cnt   <= '0;
                     last_grant <= (state == GRANT1);
                     state      <= IDLE;
                  end else begin
                     byte_cnt <= len_next;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.AXIS_TX_TDATA   = tx_data;
   assign bus.AXIS_TX_TKEEP   = tx_keep;
   assign bus.AXIS_TX_TVALID  = tx_valid;
   assign bus.AXIS_TX_TLAST   = tx_last;
   assign bus.AXIS_RX0_TREADY = rx0_ready;
   assign bus.AXIS_RX1_TREADY = rx1_ready;
   assign bus.AXIS_LEN_TDATA  = len_data;
   assign bus.AXIS_LEN_TVALID = len_valid;

endmodule

// File: tb/tb_pkt_arbiter.sv
// tb/tb_pkt_arbiter.sv - self-checking bench for pkt_arbiter
module tb_pkt_arbiter;
   import pkt_arbiter_pkg::*;

   localparam int DW = DEF_DATA_W;
   localparam int KW = DEF_KEEP_W;
   localparam int LW = DEF_LEN_W;
   localparam logic [KW-1:0] FULL = '1;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   pkt_arbiter_if #(.DATA_W(DW), .LEN_W(LW)) ifc ();
   pkt_arbiter #(.DATA_W(DW), .LEN_W(LW)) dut (.clk(clk), .reset(reset), .bus(ifc));

   always #5 clk = ~clk;

   int    vectors = 0;
   int    errors  = 0;
   int    cyc     = 0;
   beat_t exp_beats[$];
   int    exp_len[$];
   int    got_len[$];
   int    tlast_cyc = -100;
   int    len_rise_cyc = -100;
   int    rx1_ready_cycles = 0;
   bit    tx_rand  = 1'b0;
   bit    len_hold = 1'b0;
   bit    abort    = 1'b0;
   logic  prev_len_valid = 1'b0;

   function automatic beat_t mk_beat(input int src, input int id, input int b, input int nb,
                                     input logic [KW-1:0] lkeep);
      beat_t r;
      for (int i = 0; i < DW / 32; i++) r.data[i*32 +: 32] = {8'(src), 8'(id), 16'(b)};
      r.keep = (b == nb - 1) ? lkeep : FULL;
      r.last = (b == nb - 1);
      return r;
   endfunction

   // Packet length from first principles: full beats plus set bits of the last, clamped.
   function automatic int len_of(input int nb, input logic [KW-1:0] lkeep);
      longint s  = longint'(nb - 1) * KW + longint'($countones(lkeep));
      longint mx = (longint'(1) << LW) - 1;
      return int'((s > mx) ? mx : s);
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_pkt(input int src, input int id, input int nb,
                             input logic [KW-1:0] lkeep, input bit with_len);
      for (int b = 0; b < nb; b++) exp_beats.push_back(mk_beat(src, id, b, nb, lkeep));
      if (with_len) exp_len.push_back(len_of(nb, lkeep));
   endtask

   task automatic set_rx(input int src, input bit v, input beat_t bt);
      if (src == 0) begin
         ifc.AXIS_RX0_TVALID = v;
         ifc.AXIS_RX0_TDATA  = bt.data;
         ifc.AXIS_RX0_TKEEP  = bt.keep;
         ifc.AXIS_RX0_TLAST  = bt.last;
      end else begin
         ifc.AXIS_RX1_TVALID = v;
         ifc.AXIS_RX1_TDATA  = bt.data;
         ifc.AXIS_RX1_TKEEP  = bt.keep;
         ifc.AXIS_RX1_TLAST  = bt.last;
      end
   endtask

   task automatic drive(input int src, input int id, input int nb,
                        input logic [KW-1:0] lkeep, input bit gaps);
      int  b = 0;
      int  waited = 0;
      bit  hs;
      while (b < nb && !abort) begin
         set_rx(src, !(gaps && b > 0 && $urandom_range(0, 2) == 0), mk_beat(src, id, b, nb, lkeep));
         @(negedge clk);
         hs = (src == 0) ? (ifc.AXIS_RX0_TVALID && ifc.AXIS_RX0_TREADY)
                         : (ifc.AXIS_RX1_TVALID && ifc.AXIS_RX1_TREADY);
         @(posedge clk);
         #1;
         if (hs) begin
            b++;
            waited = 0;
         end else if (++waited > 3000) begin
            vectors++;
            errors++;
            $display("FAIL drive_timeout src%0d beat %0d: got no handshake, expected one within 3000 cycles", src, b);
            break;
         end
      end
      set_rx(src, 1'b0, '0);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((exp_beats.size() != 0 || exp_len.size() != 0) && n < 5000) begin
         @(posedge clk);
         n++;
      end
      check({name, "_drained"}, exp_beats.size() + exp_len.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         ifc.AXIS_TX_TREADY  = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         ifc.AXIS_LEN_TREADY = !len_hold;
      end
   end

   // Compare process: every accepted TX beat and every visible length against the model queues.
   initial begin
      beat_t act;
      beat_t eb;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            prev_len_valid = 1'b0;
         end else begin
            if (ifc.AXIS_RX1_TREADY) rx1_ready_cycles++;
            check("ready_onehot", ifc.AXIS_RX0_TREADY && ifc.AXIS_RX1_TREADY, 0);
            if (ifc.AXIS_TX_TVALID && ifc.AXIS_TX_TREADY) begin
               vectors++;
               act = '{ifc.AXIS_TX_TDATA, ifc.AXIS_TX_TKEEP, ifc.AXIS_TX_TLAST};
               if (exp_beats.size() == 0) begin
                  errors++;
                  $display("FAIL tx_beat: got unexpected beat word0=%h, expected none", act.data[31:0]);
               end else begin
                  eb = exp_beats.pop_front();
                  if (act !== eb) begin
                     errors++;
                     $display("FAIL tx_beat: got word0=%h keep=%h last=%b, expected word0=%h keep=%h last=%b",
                              act.data[31:0], act.keep, act.last, eb.data[31:0], eb.keep, eb.last);
                  end
               end
               if (ifc.AXIS_TX_TLAST) tlast_cyc = cyc;
            end
            if (ifc.AXIS_LEN_TVALID) begin
               if (!prev_len_valid) len_rise_cyc = cyc;
               if (exp_len.size() == 0) begin
                  check("len_unexpected", ifc.AXIS_LEN_TVALID, 0);
               end else begin
                  check("len_value", ifc.AXIS_LEN_TDATA, exp_len[0]);
               end
               if (ifc.AXIS_LEN_TREADY) begin
                  got_len.push_back(int'(ifc.AXIS_LEN_TDATA));
                  if (exp_len.size() != 0) void'(exp_len.pop_front());
               end
            end
            prev_len_valid = ifc.AXIS_LEN_TVALID;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish before 500us");
      $fatal(1, "watchdog");
   end

   initial begin
      set_rx(0, 1'b0, '0);
      set_rx(1, 1'b0, '0);
      ifc.AXIS_TX_TREADY  = 1'b1;
      ifc.AXIS_LEN_TREADY = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_valid", ifc.AXIS_TX_TVALID, 0);
      check("rst_rx0_ready", ifc.AXIS_RX0_TREADY, 0);
      check("rst_rx1_ready", ifc.AXIS_RX1_TREADY, 0);
      check("rst_len_valid", ifc.AXIS_LEN_TVALID, 0);
      check("rst_len_data", ifc.AXIS_LEN_TDATA, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Both requesters at once: requester 0 wins first after reset.
      got_len.delete();
      expect_pkt(0, 1, 2, FULL, 1);
      expect_pkt(1, 2, 2, FULL, 1);
      fork
         drive(0, 1, 2, FULL, 0);
         drive(1, 2, 2, FULL, 0);
      join
      wait_done("both_valid");
      check("both_len_n", got_len.size(), 2);
      check("both_len0", got_len.size() > 0 ? got_len[0] : -1, 128);
      check("both_len1", got_len.size() > 1 ? got_len[1] : -1, 128);

      // Three beats with a short last beat; length appears the cycle after TLAST.
      got_len.delete();
      expect_pkt(0, 3, 3, 64'h0000_0000_0000_000F, 1);
      drive(0, 3, 3, 64'h0000_0000_0000_000F, 0);
      wait_done("short_last");
      check("short_len", got_len.size() > 0 ? got_len[0] : -1, 132);
      check("len_latency", len_rise_cyc - tlast_cyc, 1);

      // Length slot held full blocks the pending requester 1.
      got_len.delete();
      len_hold = 1'b1;
      rx1_ready_cycles = 0;
      expect_pkt(0, 4, 2, FULL, 1);
      expect_pkt(1, 5, 2, FULL, 1);
      fork
         drive(0, 4, 2, FULL, 0);
         begin
            @(posedge clk);
            #1;
            drive(1, 5, 2, FULL, 0);
         end
         begin
            repeat (12) @(posedge clk);
            #1;
            check("held_rx1_ready", rx1_ready_cycles, 0);
            check("held_len_valid", ifc.AXIS_LEN_TVALID, 1);
            check("held_len_data", ifc.AXIS_LEN_TDATA, 128);
            len_hold = 1'b0;
         end
      join
      wait_done("len_hold");
      check("hold_len0", got_len.size() > 0 ? got_len[0] : -1, 128);
      check("hold_len1", got_len.size() > 1 ? got_len[1] : -1, 128);

      // Valid gaps and TX backpressure; sparse one-beat packet from requester 1.
      got_len.delete();
      tx_rand = 1'b1;
      expect_pkt(0, 6, 5, FULL, 1);
      expect_pkt(1, 7, 1, 64'h8000_0000_0001_0101, 1);
      fork
         drive(0, 6, 5, FULL, 1);
         begin
            @(posedge clk);
            #1;
            drive(1, 7, 1, 64'h8000_0000_0001_0101, 0);
         end
      join
      wait_done("gaps");
      tx_rand = 1'b0;
      check("gaps_len0", got_len.size() > 0 ? got_len[0] : -1, 320);
      check("sparse_len1", got_len.size() > 1 ? got_len[1] : -1, 4);

      // Long packet saturates the length.
      got_len.delete();
      expect_pkt(0, 8, 1100, FULL, 1);
      drive(0, 8, 1100, FULL, 0);
      wait_done("saturate");
      check("sat_len", got_len.size() > 0 ? got_len[0] : -1, 65535);

      // Reset mid-packet: outputs drop at once, packet abandoned, requester 0 wins again.
      got_len.delete();
      expect_pkt(0, 9, 10, FULL, 0);
      fork
         drive(0, 9, 10, FULL, 0);
         begin
            repeat (4) @(posedge clk);
            #3;
            reset = 1'b1;
            #1;
            check("mid_rst_tx_valid", ifc.AXIS_TX_TVALID, 0);
            check("mid_rst_rx0_ready", ifc.AXIS_RX0_TREADY, 0);
            check("mid_rst_rx1_ready", ifc.AXIS_RX1_TREADY, 0);
            check("mid_rst_len_valid", ifc.AXIS_LEN_TVALID, 0);
            abort = 1'b1;
         end
      join
      exp_beats.delete();
      exp_len.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      abort = 1'b0;
      check("post_rst_len_valid", ifc.AXIS_LEN_TVALID, 0);
      check("post_rst_len_data", ifc.AXIS_LEN_TDATA, 0);
      expect_pkt(0, 10, 1, FULL, 1);
      expect_pkt(1, 11, 1, 64'h0000_0000_F0F0_0000, 1);
      fork
         drive(0, 10, 1, FULL, 0);
         drive(1, 11, 1, 64'h0000_0000_F0F0_0000, 0);
      join
      wait_done("after_reset");
      check("after_rst_len_n", got_len.size(), 2);
      check("after_rst_len0", got_len.size() > 0 ? got_len[0] : -1, 64);
      check("after_rst_len1", got_len.size() > 1 ? got_len[1] : -1, 8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
